// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port cache between the boot loader, 4-beat fetch bursts and data accesses
module mem_port_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int BURST_LEN  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ld_req,
   input  logic                  ld_we,
   input  logic                  ld_last,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_wdata,
   output logic                  ld_gnt,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [1:0]            if_beat,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic                  dm_gnt,
   output logic                  dm_rvalid,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  init_done
);
   typedef enum logic [1:0] {BOOT, IDLE, BURST} state_t;
   state_t state, state_n;
   logic [1:0] cnt, cnt_n;
   logic rr, rr_n;
   logic [ADDR_WIDTH-1:0] base, base_n;
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      rr_n = rr;
      base_n = base;
      ld_gnt = 1'b0;
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
      mem_en = 1'b0;
      mem_we = 1'b0;
      mem_addr = '0;
      mem_wdata = '0;
      case (state)
         BOOT: begin
            ld_gnt = ld_req;
            mem_en = ld_req;
            mem_we = ld_req && ld_we;
            mem_addr = ld_req ? ld_addr : '0;
            mem_wdata = ld_req ? ld_wdata : '0;
            if (ld_req && ld_last) state_n = IDLE;
         end
         IDLE: begin
            // rr breaks ties only; a lone requester always wins and rr then favours the other
            if (if_req && (!dm_req || !rr)) begin
               if_gnt = 1'b1;
               mem_en = 1'b1;
               mem_addr = if_addr;
               base_n = if_addr;
               cnt_n = 2'd1;
               rr_n = 1'b1;
               state_n = BURST;
            end else if (dm_req) begin
               dm_gnt = 1'b1;
               mem_en = 1'b1;
               mem_we = dm_we;
               mem_addr = dm_addr;
               mem_wdata = dm_wdata;
               rr_n = 1'b0;
            end
         end
         BURST: begin
            mem_en = 1'b1;
            mem_addr = base + ADDR_WIDTH'(cnt);
            cnt_n = cnt + 2'd1;
            if (cnt == 2'(BURST_LEN - 1)) begin
               cnt_n = 2'd0;
               state_n = IDLE;
            end
         end
         default: state_n = BOOT;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= BOOT;
         cnt <= 2'd0;
         rr <= 1'b0;
         base <= '0;
         init_done <= 1'b0;
         if_rvalid <= 1'b0;
         if_beat <= 2'd0;
         dm_rvalid <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         rr <= rr_n;
         base <= base_n;
         init_done <= state_n != BOOT;
         if_rvalid <= if_gnt || state == BURST;
         if_beat <= state == BURST ? cnt : 2'd0;
         dm_rvalid <= dm_gnt && !dm_we;
      end
   end
   assign if_rdata = if_rvalid ? mem_rdata : '0;
   assign dm_rdata = dm_rvalid ? mem_rdata : '0;
endmodule
